// File: rtl/hvac_zone_scheduler.sv
// Multi-zone HVAC plant scheduler: per-zone hysteresis demand, round-robin grant,
// minimum run/rest timing. Define HVAC_PREEMPT_EN to enable MAX_RUN preemption.
module hvac_zone_scheduler #(
    parameter int         N_ZONES    = 4,
    parameter logic [4:0] LOWER_TEMP = 5'd18,
    parameter logic [4:0] MID_TEMP   = 5'd20,
    parameter logic [4:0] UPPER_TEMP = 5'd22,
    parameter int         MIN_RUN    = 8,
    parameter int         MIN_REST   = 4,
    parameter int         MAX_RUN    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5*N_ZONES-1:0]   temperature,
    input  logic [N_ZONES-1:0]     zone_enable,
    output logic                   heating,
    output logic                   cooling,
    output logic [N_ZONES-1:0]     zone_valve,
    output logic [1:0]             sched_state
);
    localparam int ZW      = $clog2(N_ZONES);
    localparam int CNT_MAX = (MAX_RUN > MIN_RUN) ? MAX_RUN : MIN_RUN;
    localparam int RCW     = $clog2(CNT_MAX + 1);
    localparam int SCW     = $clog2(MIN_REST + 1);

    localparam logic [RCW-1:0] RUN_MIN_LAST = RCW'(MIN_RUN - 1);
    localparam logic [SCW-1:0] REST_LAST    = SCW'(MIN_REST - 1);
    localparam logic [ZW-1:0]  LAST_ZONE    = ZW'(N_ZONES - 1);

    typedef enum logic [1:0] {
        DEM_IDLE = 2'd0,
        DEM_HEAT = 2'd1,
        DEM_COOL = 2'd2
    } demand_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_REST = 2'b10
    } state_e;

    demand_e           demand [N_ZONES];
    state_e            state, state_next;
    logic [ZW-1:0]     zone, zone_next;
    logic [ZW-1:0]     last, last_next;
    logic              mode_heat, mode_next;
    logic [RCW-1:0]    run_cnt, run_next;
    logic [SCW-1:0]    rest_cnt, rest_next;
    logic              found;
    logic [ZW-1:0]     sel;
    logic              done_run;
    logic              heating_d, cooling_d;
    logic [N_ZONES-1:0] valve_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ZONES; i++) begin
            if (rst || !zone_enable[i]) begin
                demand[i] <= DEM_IDLE;
            end else begin
                case (demand[i])
                    DEM_IDLE: begin
                        if (temperature[5*i +: 5] <= LOWER_TEMP)
                            demand[i] <= DEM_HEAT;
                        else if (temperature[5*i +: 5] >= UPPER_TEMP)
                            demand[i] <= DEM_COOL;
                    end
                    DEM_HEAT: if (temperature[5*i +: 5] >= MID_TEMP) demand[i] <= DEM_IDLE;
                    DEM_COOL: if (temperature[5*i +: 5] <= MID_TEMP) demand[i] <= DEM_IDLE;
                    default:  demand[i] <= DEM_IDLE;
                endcase
            end
        end
    end

    // Round-robin search starting just after the last served zone.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        logic [ZW-1:0] idx;
        idx   = '0;
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= N_ZONES; i++) begin
            idx = ZW'((int'(last) + i) % N_ZONES);
            if (!found && demand[idx] != DEM_IDLE) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

`ifdef HVAC_PREEMPT_EN
    localparam logic [RCW-1:0] RUN_MAX_LAST = RCW'(MAX_RUN - 1);
    logic other_demand;

    always_comb begin
        other_demand = 1'b0;
        for (int i = 0; i < N_ZONES; i++) begin
            if (ZW'(i) != zone && demand[i] != DEM_IDLE)
                other_demand = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            zone        <= '0;
            last        <= LAST_ZONE;
            mode_heat   <= 1'b0;
            run_cnt     <= '0;
            rest_cnt    <= '0;
            heating     <= 1'b0;
            cooling     <= 1'b0;
            zone_valve  <= '0;
            sched_state <= ST_IDLE;
        end else begin
            state       <= state_next;
            zone        <= zone_next;
            last        <= last_next;
            mode_heat   <= mode_next;
            run_cnt     <= run_next;
            rest_cnt    <= rest_next;
            heating     <= heating_d;
            cooling     <= cooling_d;
            zone_valve  <= valve_d;
            sched_state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        zone_next  = zone;
        last_next  = last;
        mode_next  = mode_heat;
        run_next   = run_cnt;
        rest_next  = rest_cnt;
        done_run   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_next = ST_RUN;
                    zone_next  = sel;
                    mode_next  = (demand[sel] == DEM_HEAT);
                    run_next   = '0;
                end
            end
            ST_RUN: begin
                // Losing the zone enable releases immediately, bypassing MIN_RUN.
                done_run = !zone_enable[zone] ||
                           (run_cnt >= RUN_MIN_LAST && demand[zone] == DEM_IDLE);
`ifdef HVAC_PREEMPT_EN
                done_run = done_run || (run_cnt >= RUN_MAX_LAST && other_demand);
`endif
                if (done_run) begin
                    state_next = ST_REST;
                    last_next  = zone;
                    rest_next  = '0;
                end else if (run_cnt != '1) begin
                    run_next = run_cnt + 1'b1;
                end
            end
            ST_REST: begin
                if (rest_cnt == REST_LAST)
                    state_next = ST_IDLE;
                else
                    rest_next = rest_cnt + 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        heating_d = 1'b0;
        cooling_d = 1'b0;
        valve_d   = '0;
        if (state_next == ST_RUN) begin
            heating_d          = mode_next;
            cooling_d          = !mode_next;
            valve_d[zone_next] = 1'b1;
        end
    end

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Scoreboard bench for hvac_zone_scheduler: stimulus queues expected grants,
// a negedge monitor closes each grant and compares valve, mode, length and gap.
`timescale 1ns/1ps
module tb_hvac_zone_scheduler;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [5*N-1:0] temperature;
    logic [N-1:0]   zone_enable;
    logic           heating;
    logic           cooling;
    logic [N-1:0]   zone_valve;
    logic [1:0]     sched_state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [N-1:0] valve;
        logic         heat;
        logic         cool;
        int           len;
        int           gap;
    } grant_t;

    grant_t exp_q[$];

    hvac_zone_scheduler #(
        .N_ZONES (N),
        .MIN_RUN (8),
        .MIN_REST(4),
        .MAX_RUN (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .temperature(temperature),
        .zone_enable(zone_enable),
        .heating    (heating),
        .cooling    (cooling),
        .zone_valve (zone_valve),
        .sched_state(sched_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void expect_grant(input int z, input bit heat, input int len, input int gap);
        grant_t g;
        g.valve    = '0;
        g.valve[z] = 1'b1;
        g.heat     = heat;
        g.cool     = !heat;
        g.len      = len;
        g.gap      = gap;
        exp_q.push_back(g);
    endfunction

    // Monitor: samples on the falling edge, away from DUT updates.
    logic [N-1:0] cur_valve;
    logic         cur_heat, cur_cool;
    int           cur_len, cur_gap;
    int           gap_cnt  = -1;
    bit           in_grant = 1'b0;
    grant_t       e;

    always @(negedge clk) begin
        if (rst) begin
            in_grant = 1'b0;
            gap_cnt  = -1;
        end else begin
            check("exclusive_heat_cool", heating & cooling, 0);
            check("valve_onehot0", $onehot0(zone_valve), 1);
            check("valve_matches_run",
                  ((zone_valve != '0) == (sched_state == 2'b01)) &&
                  ((heating | cooling) == (zone_valve != '0)), 1);
            if (zone_valve != '0 && !in_grant) begin
                in_grant  = 1'b1;
                cur_valve = zone_valve;
                cur_heat  = heating;
                cur_cool  = cooling;
                cur_len   = 1;
                cur_gap   = gap_cnt;
            end else if (zone_valve != '0) begin
                cur_len++;
                check("grant_stable", {zone_valve, heating, cooling}, {cur_valve, cur_heat, cur_cool});
            end else if (in_grant) begin
                in_grant = 1'b0;
                gap_cnt  = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", cur_valve, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_valve", cur_valve, e.valve);
                    check("grant_heat", cur_heat, e.heat);
                    check("grant_cool", cur_cool, e.cool);
                    check("grant_len", cur_len, e.len);
                    if (e.gap >= 0) check("grant_gap", cur_gap, e.gap);
                end
            end else if (gap_cnt >= 0) begin
                gap_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_temp(input int z, input logic [4:0] t);
        temperature[5*z +: 5] = t;
    endtask

    task automatic set_all(input logic [4:0] t);
        for (int i = 0; i < N; i++) set_temp(i, t);
    endtask

    task automatic apply_reset(input logic [4:0] t);
        rst         = 1'b1;
        zone_enable = '1;
        set_all(t);
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int z);
        z = -1;
        for (int k = 0; k < 200; k++) begin
            tick(1);
            if (zone_valve != '0) begin
                for (int i = 0; i < N; i++) if (zone_valve[i]) z = i;
                return;
            end
        end
        check("grant_timeout", 0, 1);
    endtask

    task automatic wait_release();
        for (int k = 0; k < 200; k++) begin
            if (zone_valve == '0) return;
            tick(1);
        end
        check("release_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int z;

        // Reset with every zone cold, then round-robin through all four.
        rst         = 1'b1;
        zone_enable = '1;
        set_all(5'd15);
        tick(1);
        check("reset_outputs_1", {heating, cooling, zone_valve, sched_state}, 0);
        tick(1);
        check("reset_outputs_2", {heating, cooling, zone_valve, sched_state}, 0);
        expect_grant(0, 1'b1, 8, -1);
        expect_grant(1, 1'b1, 8, 5);
        expect_grant(2, 1'b1, 8, 5);
        expect_grant(3, 1'b1, 8, 5);
        rst = 1'b0;
        tick(1);
        check("post_reset_edge1_valve", zone_valve, 0);
        tick(1);
        check("post_reset_edge2_valve", zone_valve, 4'b0001);
        check("post_reset_edge2_heat", heating, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) z = 0;
            else wait_grant(z);
            check("rr_order", z, k);
            if (z >= 0) set_temp(z, 5'd20);
            wait_release();
        end
        tick(8);

        // Hysteresis: 19 holds heat, 20 releases, then four REST cycles.
        apply_reset(5'd20);
        set_temp(1, 5'd15);
        expect_grant(1, 1'b1, 22, -1);
        wait_grant(z);
        check("hyst_zone", z, 1);
        check("hyst_heat", heating, 1);
        set_temp(1, 5'd19);
        tick(20);
        check("hyst_hold_valve", zone_valve, 4'b0010);
        set_temp(1, 5'd20);
        tick(2);
        for (int k = 0; k < 4; k++) begin
            check("hyst_rest_state", sched_state, 2'b10);
            check("hyst_rest_outputs", {heating, cooling, zone_valve}, 0);
            tick(1);
        end
        check("hyst_idle_after_rest", sched_state, 2'b00);
        tick(4);

        // Minimum run: demand clears two cycles in, plant still runs 8 cycles.
        apply_reset(5'd20);
        set_temp(2, 5'd25);
        expect_grant(2, 1'b0, 8, -1);
        wait_grant(z);
        check("minrun_zone", z, 2);
        check("minrun_cool", cooling, 1);
        tick(2);
        set_temp(2, 5'd20);
        wait_release();
        tick(8);

        // Reversal: cool zone 0, dead time, then heat zone 1.
        apply_reset(5'd20);
        set_temp(0, 5'd25);
        set_temp(1, 5'd15);
        expect_grant(0, 1'b0, 8, -1);
        expect_grant(1, 1'b1, 8, 5);
        wait_grant(z);
        check("rev_first_zone", z, 0);
        check("rev_first_cool", cooling, 1);
        set_temp(0, 5'd20);
        wait_release();
        wait_grant(z);
        check("rev_second_zone", z, 1);
        check("rev_second_heat", heating, 1);
        set_temp(1, 5'd20);
        wait_release();
        tick(8);

        // Enable drop three cycles into a grant forces REST on the next edge.
        apply_reset(5'd20);
        set_temp(0, 5'd15);
        expect_grant(0, 1'b1, 4, -1);
        wait_grant(z);
        check("override_zone", z, 0);
        tick(3);
        zone_enable[0] = 1'b0;
        tick(1);
        check("override_rest_state", sched_state, 2'b10);
        check("override_valve_off", zone_valve, 0);
        tick(8);

        // Two zones demanding continuously.
        apply_reset(5'd20);
        set_temp(0, 5'd15);
        set_temp(1, 5'd15);
`ifdef HVAC_PREEMPT_EN
        expect_grant(0, 1'b1, 32, -1);
        expect_grant(1, 1'b1, 8, 5);
        expect_grant(0, 1'b1, 8, 5);
        wait_grant(z);
        check("preempt_first_zone", z, 0);
        wait_release();
        wait_grant(z);
        check("preempt_second_zone", z, 1);
        set_temp(1, 5'd20);
        wait_release();
        wait_grant(z);
        check("preempt_third_zone", z, 0);
        set_temp(0, 5'd20);
        wait_release();
`else
        expect_grant(0, 1'b1, 42, -1);
        expect_grant(1, 1'b1, 8, 5);
        wait_grant(z);
        check("hold_first_zone", z, 0);
        tick(40);
        check("hold_valve", zone_valve, 4'b0001);
        set_temp(0, 5'd20);
        wait_release();
        wait_grant(z);
        check("hold_second_zone", z, 1);
        set_temp(1, 5'd20);
        wait_release();
`endif
        tick(8);

        check("scoreboard_drained", exp_q.size(), 0);
        check("no_open_grant", in_grant, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hvac_zone_scheduler.md
# hvac_zone_scheduler

Shares one heating/cooling plant between `N_ZONES` zones, each reporting a 5-bit temperature. Per-zone hysteresis (18/20/22 °C bands, same as the single-room air-conditioning FSM) produces heat/cool demand. A round-robin scheduler grants the plant to one zone at a time. It enforces minimum run and rest times so heat/cool reversal always passes through a dead period. Sits above the plant: drives `{heating, cooling}` and one-hot zone valves.

## Interface
- `N_ZONES`, 4, number of zones (2..8)
- `LOWER_TEMP`, 5'd18, heat-demand threshold
- `MID_TEMP`, 5'd20, demand-clear threshold
- `UPPER_TEMP`, 5'd22, cool-demand threshold
- `MIN_RUN`, 8, minimum cycles plant output is asserted per grant (≥1)
- `MIN_REST`, 4, cycles plant is forced off after each grant (≥1)
- `MAX_RUN`, 32, preemption limit (used only with `HVAC_PREEMPT_EN`; > `MIN_RUN`)
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `temperature`  in  5*N_ZONES  packed zone temps, zone i at bits [5i+4:5i], unsigned °C
- `zone_enable`  in  N_ZONES  per-zone enable; 0 forces that zone's demand idle
- `heating`  out  1  plant heat command
- `cooling`  out  1  plant cool command
- `zone_valve`  out  N_ZONES  one-hot valve of granted zone, 0 when not in RUN
- `sched_state`  out  2  00 IDLE, 01 RUN, 10 REST

## Operation
- Per-zone demand register, updated every edge from the current temperature:
  - IDLE→HEAT if temp ≤ LOWER_TEMP; IDLE→COOL if temp ≥ UPPER_TEMP.
  - HEAT→IDLE if temp ≥ MID_TEMP; COOL→IDLE if temp ≤ MID_TEMP.
  - Never HEAT↔COOL directly.
  - `zone_enable[i]`=0 → IDLE.
- Scheduler FSM:
  - **IDLE:** if any demand ≠ IDLE, select the first demanding zone searching from `(last+1) mod N_ZONES` upward. Latch zone index and mode (heat/cool). Go to RUN with `run_cnt`=0.
  - **RUN:**
    - Assert `zone_valve`=onehot(zone), plus `heating` or `cooling` per the latched mode. The mode is fixed for the whole grant.
    - `run_cnt` increments each edge, saturating.
    - Release to REST when `run_cnt` ≥ MIN_RUN−1 and the granted zone's demand is IDLE.
    - If the granted zone's `zone_enable` drops, release to REST at that edge regardless of `run_cnt` (safety override).
    - On release, `last` ← granted zone.
  - **REST:** all outputs 0. `rest_cnt` counts from 0; go to IDLE at the edge where `rest_cnt`=MIN_REST−1.
- `heating` and `cooling` are never both 1. At most one `zone_valve` bit is set.
- Reset: state IDLE, `last`=N_ZONES−1 (zone 0 highest priority first), all demands IDLE, counters 0.

## Timing
- All outputs registered. Reset values: `heating`=0, `cooling`=0, `zone_valve`=0, `sched_state`=00.
- Temperature set before edge k → demand valid after k → grant outputs valid after edge k+1 (2-edge latency from idle).
- Per grant: outputs high ≥ MIN_RUN cycles, except on enable drop.
- Off gap between consecutive grants: exactly MIN_REST+1 cycles (REST plus one IDLE cycle).
- Demand clearing during RUN before MIN_RUN: the grant holds until MIN_RUN is met; the zone may re-demand afterwards.
- A zone re-demanding during REST is eligible at IDLE under normal round-robin order.
- `rst` asserted in any state: outputs 0 and state IDLE at that edge; no rest period is enforced after reset.

## Configuration
- `HVAC_PREEMPT_EN` defined: in RUN, when `run_cnt` ≥ MAX_RUN−1 and any other zone demands, release to REST even if the granted zone still demands. Round-robin order then serves the other zone.
- Not defined: a zone holds the plant until its demand clears or it is disabled. `MAX_RUN` is unused.

## Test plan
Defaults: N_ZONES=4, MIN_RUN=8, MIN_REST=4, MAX_RUN=32.
- **Reset:** `rst`=1 for 2 cycles with all temps 15, all enabled → outputs 0 during reset. At the 2nd edge after release: `heating`=1, `zone_valve`=0001.
- **Hysteresis:**
  - Zone 1 only, temp 15 → `heating`=1, valve 0010.
  - Temp 19 for 20 cycles → held.
  - Temp 20 → released; `sched_state`=10 for 4 cycles; outputs 0.
- **Min run:** zone 2 temp 25 → `cooling`=1. Drive temp 20 two cycles later → `cooling` stays 1 for exactly 8 cycles in total.
- **Round-robin:** all zones at 15. Bench drives each granted zone to 20 on grant → valve sequence 0001, 0010, 0100, 1000, each gap 5 cycles.
- **Reversal/dead time:** zone 0 at 25, zone 1 at 15 → cooling with valve 0001. Clear zone 0 → ≥5 cycles of `{heating,cooling}`=00, then heating with valve 0010. The two outputs are never both high.
- **Override/preempt:**
  - Drop `zone_enable[0]` 3 cycles into a grant → REST next edge.
  - With `HVAC_PREEMPT_EN`: zones 0 and 1 held at 15 → zone 0 released after 32 cycles; zone 1 granted 5 cycles later.
